stream_argmax: RTL and testbench

- Consumes the word-serial neuron output stream of the final network layer, one dataWidth word per in_valid cycle, in neuron-index order 0..numInput-1.
- Outputs the index and value of the largest word in each frame; this index is the classification result.
- Sits directly downstream of the layer serializer. Compares values as signed fixed-point.
- Detects frames that stall mid-way and aborts them with an error pulse.

---
 rtl/stream_argmax.sv | 117 +++++++++++
 tb/tb_stream_argmax.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_argmax.sv
// stream_argmax: tracks the index and value of the largest signed word in each
// fixed-length frame of a word-serial neuron output stream. It emits a one-cycle
// result pulse after the last word of a frame. A frame that goes quiet for
// gapLimit consecutive cycles is aborted with a one-cycle error pulse.
module stream_argmax #(
   parameter int dataWidth = 16,
   parameter int numInput  = 10,
   parameter int idxWidth  = $clog2(numInput),
   parameter int gapLimit  = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   input  logic [dataWidth-1:0] in_data,
   output logic                 out_valid,
   output logic [idxWidth-1:0]  out_index,
   output logic [dataWidth-1:0] out_value,
   output logic                 busy,
   output logic                 frame_err
);

   localparam int gapWidth = $clog2(gapLimit + 1);

   typedef enum logic {
      IDLE,
      ACCUM
   } state_t;

   state_t                       state, state_nx;
   logic [idxWidth-1:0]          count, count_nx;
   logic [gapWidth-1:0]          gap, gap_nx;
   logic signed [dataWidth-1:0]  max_r, max_nx;
   logic [idxWidth-1:0]          idx_r, idx_nx;
   logic                         valid_nx, err_nx;
   logic [idxWidth-1:0]          oidx_nx;
   logic [dataWidth-1:0]         oval_nx;

   // State and datapath registers, all cleared by the asynchronous reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         count     <= '0;
         gap       <= '0;
         max_r     <= '0;
         idx_r     <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         out_index <= '0;
         out_value <= '0;
      end else begin
         state     <= state_nx;
         count     <= count_nx;
         gap       <= gap_nx;
         max_r     <= max_nx;
         idx_r     <= idx_nx;
         out_valid <= valid_nx;
         frame_err <= err_nx;
         out_index <= oidx_nx;
         out_value <= oval_nx;
      end
   end

   // Next-state logic: running argmax, frame completion and gap timeout
   always_comb begin
      state_nx = state;
      count_nx = count;
      gap_nx   = gap;
      max_nx   = max_r;
      idx_nx   = idx_r;
      valid_nx = 1'b0;
      err_nx   = 1'b0;
      oidx_nx  = out_index;
      oval_nx  = out_value;
      busy     = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               max_nx   = $signed(in_data);
               idx_nx   = '0;
               count_nx = idxWidth'(1);
               gap_nx   = '0;
               state_nx = ACCUM;
            end
         end
         ACCUM: begin
            busy = 1'b1;
            if (in_valid) begin
               gap_nx = '0;
               // Strict greater-than: on a tie the earlier index is kept
               if ($signed(in_data) > max_r) begin
                  max_nx = $signed(in_data);
                  idx_nx = count;
               end
               if (count == idxWidth'(numInput - 1)) begin
                  // The result includes the word accepted this cycle
                  valid_nx = 1'b1;
                  oidx_nx  = idx_nx;
                  oval_nx  = max_nx;
                  count_nx = '0;
                  state_nx = IDLE;
               end else begin
                  count_nx = count + idxWidth'(1);
               end
            end else if (gap == gapWidth'(gapLimit - 1)) begin
               err_nx   = 1'b1;
               gap_nx   = '0;
               count_nx = '0;
               state_nx = IDLE;
            end else begin
               gap_nx = gap + gapWidth'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_stream_argmax.sv
// Directed testbench for stream_argmax (dataWidth=16, numInput=10, gapLimit=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_stream_argmax;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic [15:0] in_data;
   logic        out_valid;
   logic [3:0]  out_index;
   logic [15:0] out_value;
   logic        busy;
   logic        frame_err;

   int total = 0;
   int bad   = 0;

   int          cyc = 0;
   int          errs = 0;
   logic [3:0]  vq_idx[$];
   logic [15:0] vq_val[$];
   int          vq_cyc[$];

   stream_argmax #(
      .dataWidth(16),
      .numInput(10),
      .gapLimit(8)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .in_valid(in_valid),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_index(out_index),
      .out_value(out_value),
      .busy(busy),
      .frame_err(frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter for pulse spacing
   always @(posedge clk) cyc <= cyc + 1;

   // Record every result pulse and error pulse
   always @(negedge clk) begin
      if (rstn && out_valid) begin
         vq_idx.push_back(out_index);
         vq_val.push_back(out_value);
         vq_cyc.push_back(cyc);
      end
      if (rstn && frame_err) errs = errs + 1;
   end

   task automatic clear_q();
      vq_idx.delete();
      vq_val.delete();
      vq_cyc.delete();
   endtask

   task automatic put(input logic [15:0] v);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = '0;
      end
   endtask

   task automatic send_frame(input logic [15:0] f[10]);
      for (int i = 0; i < 10; i++) put(f[i]);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      repeat (3) @(negedge clk);
      total++;
      if ({out_valid, out_index, out_value, busy, frame_err} !== 23'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want 0", {out_valid, out_index, out_value, busy, frame_err});
      end
      rstn = 1'b1;
      idle(2);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_basic();
      logic [15:0] f[10];
      f = '{16'd3, 16'd7, 16'hFFFE, 16'd15, 16'd1, 16'd0, 16'd9, 16'd4, 16'd15, 16'hFFF8};
      clear_q();
      send_frame(f);
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_index !== 4'd3 || out_value !== 16'd15 || busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_result: got v=%b i=%0d val=%0d busy=%b want v=1 i=3 val=15 busy=0",
                  out_valid, out_index, out_value, busy);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || out_index !== 4'd3 || out_value !== 16'd15) begin
         bad++;
         $display("FAIL basic_pulse_hold: got v=%b i=%0d val=%0d want v=0 i=3 val=15",
                  out_valid, out_index, out_value);
      end
      idle(1);
      total++;
      if (vq_idx.size() != 1) begin
         bad++;
         $display("FAIL basic_pulse_count: got %0d want 1", vq_idx.size());
      end
   endtask

   task automatic test_negative();
      logic [15:0] f[10];
      f = '{16'hFFFB, 16'hFFFD, 16'hFFF7, 16'hFFFD, 16'hFF9C,
            16'hFFF9, 16'hFFFC, 16'hFFFA, 16'hFFF8, 16'hFFFE};
      clear_q();
      send_frame(f);
      idle(2);
      total++;
      if (vq_idx.size() != 1 || vq_idx[0] !== 4'd9 || vq_val[0] !== 16'hFFFE) begin
         bad++;
         $display("FAIL all_negative: got n=%0d i=%0d val=%h want n=1 i=9 val=fffe",
                  vq_idx.size(), vq_idx.size() ? vq_idx[0] : 4'd0, vq_val.size() ? vq_val[0] : 16'd0);
      end
   endtask

   task automatic test_most_negative();
      logic [15:0] f[10];
      for (int i = 0; i < 10; i++) f[i] = 16'h8000;
      f[9] = 16'hFFFF;
      clear_q();
      send_frame(f);
      idle(1);
      for (int i = 0; i < 10; i++) f[i] = 16'h8000;
      f[0] = 16'h8001;
      send_frame(f);
      idle(2);
      total++;
      if (vq_idx.size() != 2) begin
         bad++;
         $display("FAIL min_count: got %0d want 2", vq_idx.size());
      end else begin
         total++;
         if (vq_idx[0] !== 4'd9 || vq_val[0] !== 16'hFFFF) begin
            bad++;
            $display("FAIL min_last_wins: got i=%0d val=%h want i=9 val=ffff", vq_idx[0], vq_val[0]);
         end
         total++;
         if (vq_idx[1] !== 4'd0 || vq_val[1] !== 16'h8001) begin
            bad++;
            $display("FAIL min_never_wins: got i=%0d val=%h want i=0 val=8001", vq_idx[1], vq_val[1]);
         end
      end
   endtask

   task automatic test_gaps();
      logic [15:0] f[10];
      int e0;
      int busy_bad;
      f = '{16'd3, 16'd7, 16'hFFFE, 16'd15, 16'd1, 16'd0, 16'd9, 16'd4, 16'd15, 16'hFFF8};
      clear_q();
      e0 = errs;
      busy_bad = 0;
      for (int i = 0; i < 10; i++) begin
         put(f[i]);
         if (i == 2 || i == 6) begin
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               if (busy !== 1'b1) busy_bad++;
               in_valid = 1'b0;
            end
         end
      end
      idle(2);
      total++;
      if (busy_bad != 0) begin
         bad++;
         $display("FAIL gaps_busy: got %0d low samples want 0", busy_bad);
      end
      total++;
      if (errs != e0) begin
         bad++;
         $display("FAIL gaps_no_err: got %0d errors want 0", errs - e0);
      end
      total++;
      if (vq_idx.size() != 1 || out_index !== 4'd3 || out_value !== 16'd15) begin
         bad++;
         $display("FAIL gaps_result: got n=%0d i=%0d val=%0d want n=1 i=3 val=15",
                  vq_idx.size(), out_index, out_value);
      end
   endtask

   task automatic test_timeout();
      logic [15:0] f[10];
      int e0;
      clear_q();
      e0 = errs;
      for (int i = 0; i < 4; i++) put(16'(20 + i));
      // Eight idle cycles: still busy and no error while they elapse
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         total++;
         if (busy !== 1'b1 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_wait_%0d: got busy=%b err=%b want busy=1 err=0", k, busy, frame_err);
         end
      end
      @(negedge clk);
      total++;
      if (frame_err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
          out_index !== 4'd3 || out_value !== 16'd15) begin
         bad++;
         $display("FAIL timeout_abort: got err=%b busy=%b v=%b i=%0d val=%0d want err=1 busy=0 v=0 i=3 val=15",
                  frame_err, busy, out_valid, out_index, out_value);
      end
      @(negedge clk);
      total++;
      if (frame_err !== 1'b0) begin
         bad++;
         $display("FAIL timeout_pulse_width: got %b want 0", frame_err);
      end
      for (int i = 0; i < 10; i++) f[i] = 16'(i);
      send_frame(f);
      idle(2);
      total++;
      if (vq_idx.size() != 1 || out_index !== 4'd9 || out_value !== 16'd9 || errs != e0 + 1) begin
         bad++;
         $display("FAIL timeout_recover: got n=%0d i=%0d val=%0d errs=%0d want n=1 i=9 val=9 errs=1",
                  vq_idx.size(), out_index, out_value, errs - e0);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a[10];
      logic [15:0] b[10];
      int e0;
      a = '{16'd50, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
      b = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd60, 16'd6, 16'd7, 16'd8, 16'd9};
      clear_q();
      e0 = errs;
      send_frame(a);
      send_frame(b);
      idle(2);
      total++;
      if (vq_idx.size() != 2 || errs != e0) begin
         bad++;
         $display("FAIL b2b_count: got pulses=%0d errs=%0d want 2 0", vq_idx.size(), errs - e0);
      end else begin
         total++;
         if (vq_idx[0] !== 4'd0 || vq_val[0] !== 16'd50) begin
            bad++;
            $display("FAIL b2b_first: got i=%0d val=%0d want i=0 val=50", vq_idx[0], vq_val[0]);
         end
         total++;
         if (vq_idx[1] !== 4'd5 || vq_val[1] !== 16'd60) begin
            bad++;
            $display("FAIL b2b_second: got i=%0d val=%0d want i=5 val=60", vq_idx[1], vq_val[1]);
         end
         total++;
         if (vq_cyc[1] - vq_cyc[0] != 10) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d want 10", vq_cyc[1] - vq_cyc[0]);
         end
      end
   endtask

   task automatic test_midframe_reset();
      logic [15:0] f[10];
      int e0;
      for (int i = 0; i < 5; i++) put(16'(100 + i));
      @(negedge clk);
      in_valid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      total++;
      if ({out_valid, out_index, out_value, busy, frame_err} !== 23'd0) begin
         bad++;
         $display("FAIL midreset_outputs: got %h want 0", {out_valid, out_index, out_value, busy, frame_err});
      end
      @(negedge clk);
      rstn = 1'b1;
      clear_q();
      e0 = errs;
      idle(12);
      total++;
      if (vq_idx.size() != 0 || errs != e0) begin
         bad++;
         $display("FAIL midreset_silent: got pulses=%0d errs=%0d want 0 0", vq_idx.size(), errs - e0);
      end
      f = '{16'd3, 16'd7, 16'hFFFE, 16'd15, 16'd1, 16'd0, 16'd9, 16'd4, 16'd15, 16'hFFF8};
      send_frame(f);
      idle(2);
      total++;
      if (vq_idx.size() != 1 || out_index !== 4'd3 || out_value !== 16'd15) begin
         bad++;
         $display("FAIL midreset_next_frame: got n=%0d i=%0d val=%0d want n=1 i=3 val=15",
                  vq_idx.size(), out_index, out_value);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_most_negative();
      test_gaps();
      test_timeout();
      test_back_to_back();
      test_midframe_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
